// File: rtl/stopwatch_ctrl.sv
// Run/stop sequencer for the four-digit stopwatch: button conditioning, mode latch,
// preset load value and tick gating toward the BCD digit counter.

module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam logic [15:0] COUNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync_p0;
    logic        sync_p1;
    logic        level;
    logic        level_d;
    logic [15:0] count;

    // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            count   <= 16'd0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            level_d <= level;
            if (sync_p1 == level) begin
                count <= 16'd0;
            end else if (count == COUNT_MAX) begin
                level <= sync_p1;
                count <= 16'd0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

    assign press = level & ~level_d;
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        btn_toggle,
    input  logic        btn_clear,
    input  logic [1:0]  mode_sel,
    input  logic [3:0]  init_val_one,
    input  logic [3:0]  init_val_two,
    input  logic        at_limit,
    output logic        cnt_load,
    output logic [15:0] load_value,
    output logic        cnt_en,
    output logic        cnt_up,
    output logic        running,
    output logic        done
);
    typedef enum logic [2:0] {LOAD, IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state;
    logic [1:0] mode_q;
    logic       p_tog;
    logic       p_clr;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    function automatic logic [15:0] preset_value(input logic [1:0] mode,
                                                 input logic [3:0] lo,
                                                 input logic [3:0] hi);
        case (mode)
            2'b00:   return 16'h0000;
            2'b01:   return 16'h9999;
            2'b10:   return {clamp_bcd(hi), clamp_bcd(lo), 8'h00};
            default: return {clamp_bcd(hi), clamp_bcd(lo), 8'h99};
        endcase
    endfunction

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_toggle (
        .clock (clock),
        .reset (reset),
        .raw   (btn_toggle),
        .press (p_tog)
    );

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock (clock),
        .reset (reset),
        .raw   (btn_clear),
        .press (p_clr)
    );

    // Mode and load value are registered on entry to LOAD so they hold for the whole LOAD cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            cnt_load   <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            mode_q     <= 2'b00;
            load_value <= 16'h0000;
        end else if (p_clr) begin
            state      <= LOAD;
            cnt_load   <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            mode_q     <= mode_sel;
            load_value <= preset_value(mode_sel, init_val_one, init_val_two);
        end else begin
            case (state)
                LOAD: begin
                    state    <= IDLE;
                    cnt_load <= 1'b0;
                    mode_q   <= mode_sel;
                end
                IDLE: begin
                    if (p_tog) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (mode_sel != mode_q) begin
                        state      <= LOAD;
                        cnt_load   <= 1'b1;
                        mode_q     <= mode_sel;
                        load_value <= preset_value(mode_sel, init_val_one, init_val_two);
                    end
                end
                RUN: begin
                    if (p_tog) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick && at_limit) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (p_tog) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state    <= LOAD;
                    cnt_load <= 1'b1;
                    running  <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_up = ~mode_q[0];
    assign cnt_en = tick & (state == RUN) & ~at_limit;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected load values and count enables are
// queued as stimulus is driven and compared when the DUT produces them.

module tb_stopwatch_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        btn_toggle;
    logic        btn_clear;
    logic [1:0]  mode_sel;
    logic [3:0]  init_val_one;
    logic [3:0]  init_val_two;
    logic        at_limit;
    logic        cnt_load;
    logic [15:0] load_value;
    logic        cnt_en;
    logic        cnt_up;
    logic        running;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_loads[$];
    logic        exp_ups[$];
    logic        exp_ens[$];
    logic [15:0] got_loads[$];
    logic        got_ups[$];
    int          run_rises;
    logic        run_prev;

    always #5 clock = ~clock;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .btn_toggle   (btn_toggle),
        .btn_clear    (btn_clear),
        .mode_sel     (mode_sel),
        .init_val_one (init_val_one),
        .init_val_two (init_val_two),
        .at_limit     (at_limit),
        .cnt_load     (cnt_load),
        .load_value   (load_value),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .running      (running),
        .done         (done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drive buttons for hold cycles, then release; record loads and RUN entries seen.
    task automatic press(input logic tog, input logic clr, input int hold, input int total);
        btn_toggle = tog;
        btn_clear  = clr;
        for (int i = 0; i < total; i++) begin
            if (i == hold) begin
                btn_toggle = 1'b0;
                btn_clear  = 1'b0;
            end
            cyc();
            if (cnt_load === 1'b1) begin
                got_loads.push_back(load_value);
                got_ups.push_back(cnt_up);
            end
            if (running === 1'b1 && run_prev !== 1'b1) run_rises++;
            run_prev = running;
        end
        btn_toggle = 1'b0;
        btn_clear  = 1'b0;
    endtask

    task automatic clear_obs();
        exp_loads.delete();
        exp_ups.delete();
        got_loads.delete();
        got_ups.delete();
        run_rises = 0;
        run_prev  = running;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset = 1'b1; tick = 1'b1; btn_toggle = 1'b0; btn_clear = 1'b0;
        mode_sel = 2'b00; init_val_one = 4'd0; init_val_two = 4'd0; at_limit = 1'b0;
        cyc(); cyc();
        exp_loads.push_back(16'h0000);
        checks++; if (cnt_load !== 1'b1) begin failures++; $display("FAIL reset_cnt_load got=%b want=1", cnt_load); end
        e = exp_loads.pop_front();
        checks++; if (load_value !== e) begin failures++; $display("FAIL reset_load_value got=%h want=%h", load_value, e); end
        checks++; if (cnt_en !== 1'b0) begin failures++; $display("FAIL reset_cnt_en got=%b want=0", cnt_en); end
        checks++; if (cnt_up !== 1'b1) begin failures++; $display("FAIL reset_cnt_up got=%b want=1", cnt_up); end
        checks++; if (running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_run_done got=%b%b want=00", running, done); end
        reset = 1'b0; tick = 1'b0;
        #1;
        checks++; if (cnt_load !== 1'b1) begin failures++; $display("FAIL release_load got=%b want=1", cnt_load); end
        cyc();
        checks++; if (cnt_load !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL release_idle got=%b%b want=00", cnt_load, running); end
    endtask

    task automatic test_run_up();
        logic e;
        clear_obs();
        press(1'b1, 1'b0, 10, 22);
        checks++; if (running !== 1'b1 || run_rises != 1) begin failures++; $display("FAIL run_up_enter got=%b rises=%0d want=1 rises=1", running, run_rises); end
        checks++; if (got_loads.size() != 0) begin failures++; $display("FAIL run_up_noload got=%0d want=0", got_loads.size()); end
        for (int i = 0; i < 12; i++) begin
            tick = 1'($urandom_range(0, 1));
            if (i == 0) tick = 1'b1;
            exp_ens.push_back(tick);
            #1;
            e = exp_ens.pop_front();
            checks++; if (cnt_en !== e || cnt_up !== 1'b1) begin failures++; $display("FAIL run_up_en[%0d] got=%b up=%b want=%b up=1", i, cnt_en, cnt_up, e); end
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic test_preset();
        logic [15:0] e;
        logic        u;
        // Clear from RUN with preset mode 11, digits 7/3.
        clear_obs();
        mode_sel = 2'b11; init_val_one = 4'd3; init_val_two = 4'd7;
        exp_loads.push_back(16'h7399); exp_ups.push_back(1'b0);
        press(1'b0, 1'b1, 10, 22);
        // Nibble above 9 clamps.
        init_val_two = 4'hC;
        exp_loads.push_back(16'h9399); exp_ups.push_back(1'b0);
        press(1'b0, 1'b1, 10, 22);
        // Mode changes while IDLE reload without a button.
        mode_sel = 2'b01;
        exp_loads.push_back(16'h9999); exp_ups.push_back(1'b0);
        press(1'b0, 1'b0, 0, 4);
        mode_sel = 2'b10; init_val_one = 4'hA; init_val_two = 4'd5;
        exp_loads.push_back(16'h5900); exp_ups.push_back(1'b1);
        press(1'b0, 1'b0, 0, 4);
        mode_sel = 2'b00;
        exp_loads.push_back(16'h0000); exp_ups.push_back(1'b1);
        press(1'b0, 1'b0, 0, 4);
        checks++; if (got_loads.size() != exp_loads.size()) begin failures++; $display("FAIL preset_load_count got=%0d want=%0d", got_loads.size(), exp_loads.size()); end
        while (exp_loads.size() > 0 && got_loads.size() > 0) begin
            e = exp_loads.pop_front();
            u = exp_ups.pop_front();
            checks++; if (got_loads[0] !== e || got_ups[0] !== u) begin failures++; $display("FAIL preset_load got=%h up=%b want=%h up=%b", got_loads[0], got_ups[0], e, u); end
            void'(got_loads.pop_front());
            void'(got_ups.pop_front());
        end
        checks++; if (running !== 1'b0 || cnt_load !== 1'b0 || run_rises != 0) begin failures++; $display("FAIL preset_idle got=%b%b rises=%0d want=00 rises=0", running, cnt_load, run_rises); end
    endtask

    task automatic test_limit();
        clear_obs();
        press(1'b1, 1'b0, 10, 22);
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL limit_enter_run got=%b want=1", running); end
        at_limit = 1'b1; tick = 1'b1;
        exp_ens.push_back(1'b0);
        #1;
        checks++; if (cnt_en !== exp_ens.pop_front()) begin failures++; $display("FAIL limit_cnt_en got=%b want=0", cnt_en); end
        cyc();
        tick = 1'b0;
        checks++; if (done !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL limit_done got=done%b run%b want=done1 run0", done, running); end
        clear_obs();
        press(1'b1, 1'b0, 10, 22);
        checks++; if (done !== 1'b1 || running !== 1'b0 || run_rises != 0) begin failures++; $display("FAIL done_ignores_toggle got=done%b run%b rises=%0d want=done1 run0 rises=0", done, running, run_rises); end
        at_limit = 1'b0; tick = 1'b1;
        #1;
        checks++; if (cnt_en !== 1'b0) begin failures++; $display("FAIL done_cnt_en got=%b want=0", cnt_en); end
        cyc();
        tick = 1'b0;
    endtask

    task automatic test_bounce();
        clear_obs();
        exp_loads.push_back(16'h0000);
        press(1'b0, 1'b1, 10, 22);
        checks++; if (got_loads.size() != 1 || got_loads[0] !== exp_loads[0] || done !== 1'b0) begin failures++; $display("FAIL bounce_clear loads=%0d done=%b want=1 load 0000 done=0", got_loads.size(), done); end
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            btn_toggle = ((i / 2) % 2 == 0);
            cyc();
            if (running === 1'b1 && run_prev !== 1'b1) run_rises++;
            run_prev = running;
        end
        checks++; if (running !== 1'b0 || run_rises != 0) begin failures++; $display("FAIL bounce_glitch got=%b rises=%0d want=0 rises=0", running, run_rises); end
        press(1'b1, 1'b0, 12, 24);
        checks++; if (running !== 1'b1 || run_rises != 1) begin failures++; $display("FAIL bounce_hold got=%b rises=%0d want=1 rises=1", running, run_rises); end
    endtask

    task automatic test_pause_clear();
        clear_obs();
        press(1'b1, 1'b0, 10, 22);
        checks++; if (running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL pause_enter got=run%b done%b want=run0 done0", running, done); end
        mode_sel = 2'b01;
        press(1'b0, 1'b0, 0, 6);
        checks++; if (got_loads.size() != 0) begin failures++; $display("FAIL pause_mode_ignored loads=%0d want=0", got_loads.size()); end
        clear_obs();
        exp_loads.push_back(16'h9999); exp_ups.push_back(1'b0);
        press(1'b1, 1'b1, 10, 22);
        checks++; if (got_loads.size() != 1) begin failures++; $display("FAIL pause_clr_loads got=%0d want=1", got_loads.size()); end
        else begin
            checks++; if (got_loads[0] !== exp_loads[0] || got_ups[0] !== exp_ups[0]) begin failures++; $display("FAIL pause_clr_value got=%h up=%b want=%h up=%b", got_loads[0], got_ups[0], exp_loads[0], exp_ups[0]); end
        end
        checks++; if (run_rises != 0 || running !== 1'b0) begin failures++; $display("FAIL pause_clr_norun rises=%0d run=%b want=0 0", run_rises, running); end
    endtask

    task automatic test_reset_mid_run();
        clear_obs();
        press(1'b1, 1'b0, 10, 22);
        checks++; if (running !== 1'b1 || cnt_up !== 1'b0) begin failures++; $display("FAIL midrun_enter got=run%b up%b want=run1 up0", running, cnt_up); end
        tick = 1'b1;
        #1;
        checks++; if (cnt_en !== 1'b1) begin failures++; $display("FAIL midrun_tick got=%b want=1", cnt_en); end
        cyc();
        reset = 1'b1; mode_sel = 2'b00;
        #1;
        checks++; if (cnt_en !== 1'b0 || cnt_load !== 1'b1) begin failures++; $display("FAIL midrun_reset got=en%b load%b want=en0 load1", cnt_en, cnt_load); end
        checks++; if (running !== 1'b0 || load_value !== 16'h0000 || cnt_up !== 1'b1) begin failures++; $display("FAIL midrun_reset_out got=run%b val%h up%b want=run0 val0000 up1", running, load_value, cnt_up); end
        cyc(); cyc();
        reset = 1'b0;
        #1;
        checks++; if (cnt_load !== 1'b1 || cnt_en !== 1'b0) begin failures++; $display("FAIL midrun_release got=load%b en%b want=load1 en0", cnt_load, cnt_en); end
        cyc();
        checks++; if (cnt_load !== 1'b0 || running !== 1'b0 || cnt_en !== 1'b0) begin failures++; $display("FAIL midrun_idle got=load%b run%b en%b want=000", cnt_load, running, cnt_en); end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_preset();
        test_limit();
        test_bounce();
        test_pause_clear();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/stop sequencer for the four-digit stopwatch. It sits between the raw push-buttons and the digit counter:
- debounces the toggle and clear buttons;
- latches the counting mode;
- computes the preset load value;
- gates the stopwatch tick into single-cycle count enables;
- stops the count at the terminal value.

The display path and clock divider are unchanged. The counter takes only `cnt_load`/`load_value`/`cnt_en`/`cnt_up` from this block.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a button level change is accepted. Legal range is 2 to 65535.

Ports:
- `clock` in 1: system clock. All state is on the rising edge.
- `reset` in 1: asynchronous, active-high system reset.
- `tick` in 1: one-cycle stopwatch increment strobe from the clock divider, synchronous to `clock`.
- `btn_toggle` in 1: raw start/stop button, asynchronous, active-high.
- `btn_clear` in 1: raw clear button, asynchronous, active-high.
- `mode_sel` in 2: counting mode.
  - 00 = up from 00.00
  - 01 = down from 99.99
  - 10 = up from preset
  - 11 = down from preset
- `init_val_one` in 4: preset digit2, BCD.
- `init_val_two` in 4: preset digit3, BCD.
- `at_limit` in 1: from the counter. High when the count equals 99.99 (up) or 00.00 (down).
- `cnt_load` out 1: one-cycle load strobe to the counter.
- `load_value` out 16: {digit3, digit2, digit1, digit0}, BCD. Valid whenever `cnt_load` is high.
- `cnt_en` out 1: one-cycle count strobe.
- `cnt_up` out 1: count direction. 1 = up.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
Button conditioning:
- Each button passes through a 2-flop synchronizer, then a debounce counter.
- The counter resets whenever the synchronized value equals the debounced level.
- When it reaches `DEBOUNCE_CYCLES`, the debounced level flips.
- A rising edge of the debounced level produces a one-cycle press pulse (`p_tog`, `p_clr`). Releases generate nothing.

Mode latch:
- `mode_sel` is captured into `mode_q` only in the LOAD state.
- `cnt_up` = ~`mode_q[0]`.

Load value, from `mode_q`:
- 00 → 0x0000
- 01 → 0x9999
- 10 → {`init_val_two`, `init_val_one`, 8'h00}
- 11 → {`init_val_two`, `init_val_one`, 8'h99}
- Any preset nibble > 9 is clamped to 9.
- Presets are sampled in LOAD only.

States:
- LOAD: one cycle; `cnt_load`=1; captures `mode_sel`; always goes to IDLE.
- IDLE: `p_tog` → RUN; `mode_sel` ≠ `mode_q` → LOAD.
- RUN: `p_tog` → PAUSE; `tick` & `at_limit` → DONE.
- PAUSE: `p_tog` → RUN.
- DONE: `p_tog` ignored.
- Any state: `p_clr` → LOAD. This has priority over every other transition, including a same-cycle `p_tog` or `tick`.
- In RUN, PAUSE and DONE, changes on `mode_sel` are ignored until clear.

Output rules:
- `cnt_en` = `tick` & (state==RUN) & ~`at_limit`. This is the only combinational output.
- The counter never passes its terminal value.
- In RUN, a `p_tog` and a `tick` in the same cycle: that tick still counts. The state moves to PAUSE on the next edge.

## Timing
Reset:
- State = LOAD, `mode_q`=00, debounced levels=0, debounce counters=0.
- During reset: `cnt_load`=1, `load_value`=0x0000, `cnt_en`=0, `cnt_up`=1, `running`=0, `done`=0.
- First edge after reset deassertion: LOAD → IDLE. `mode_q` takes `mode_sel` on that edge.
- Reset asserted mid-RUN returns immediately (asynchronously) to LOAD. No further `cnt_en` is issued.

Latency:
- Raw button edge held stable → press pulse: 2 + `DEBOUNCE_CYCLES` cycles, ±1 for synchronizer phase.
- Press pulse → state change: next rising edge.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no pulse.

Registered outputs:
- `cnt_load`, `running` and `done` are decoded from registered state only.
- `load_value` is registered in LOAD and is stable for the whole LOAD cycle.

Hold behaviour:
- Holding a button produces exactly one pulse.
- Toggle and clear debounce independently.

## Test plan
- Reset, `mode_sel`=00, `DEBOUNCE_CYCLES`=4, press toggle 10 cycles → one `cnt_load` with 0x0000, then RUN. Thereafter `cnt_en` equals `tick` and `cnt_up`=1.
- `mode_sel`=11, presets 3/7, clear → LOAD with `load_value`=0x7399 and `cnt_up`=0. Preset nibble 0xC → clamped, `load_value`=0x9399.
- In RUN, hold `at_limit`=1 and pulse `tick` → `cnt_en` stays 0. Next edge `done`=1 and `running`=0. Further toggle presses leave DONE.
- Bounce toggle in 2-cycle bursts for 20 cycles, then hold → exactly one `p_tog`; IDLE → RUN once.
- `p_tog` and `p_clr` in the same cycle while in PAUSE → LOAD, then IDLE, never RUN. Change `mode_sel` during PAUSE → no LOAD until clear.
- Assert `reset` in the cycle a `tick` arrives in RUN → `cnt_en` is 0 during reset, `cnt_load`=1, and the state is LOAD after release.
